id_scoreboard: RTL and testbench

- Hazard and stall controller for the decode stage.
- Keeps a pending-write bitmap of destination registers for issued long-latency instructions (loads, multi-cycle ops). It clears a bit when that register is written back.
- Stalls ID when the decoded instruction reads or rewrites a pending register. Merges that with the EX multi-cycle stall request into the pipeline stall vector.
- Sits beside the decode stage and drives the stall inputs of the pc/if_id/id_ex/ex_mem/mem_wb registers.

---
 rtl/id_scoreboard.sv | 117 +++++++++++
 tb/tb_id_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - decode-stage scoreboard: pending-write bitmap, hazard stall, stall watchdog
module id_scoreboard #(
    parameter int N_REG_ADDR    = 5,
    parameter int STALL_TIMEOUT = 255,
    parameter int N_CNT         = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_id_valid,
    input  logic                     i_id_reg_0_ren,
    input  logic [N_REG_ADDR-1:0]    i_id_reg_0_addr,
    input  logic                     i_id_reg_1_ren,
    input  logic [N_REG_ADDR-1:0]    i_id_reg_1_addr,
    input  logic                     i_id_reg_wen,
    input  logic [N_REG_ADDR-1:0]    i_id_reg_waddr,
    input  logic                     i_id_long,
    input  logic                     i_ex_stallreq,
    input  logic                     i_wb_wen,
    input  logic [N_REG_ADDR-1:0]    i_wb_waddr,
    input  logic                     i_flush,
    output logic [5:0]               o_stall,
    output logic                     o_id_issue,
    output logic [2**N_REG_ADDR-1:0] o_pending,
    output logic [N_CNT-1:0]         o_stall_cnt,
    output logic                     o_deadlock
);

    localparam int N_REGS = 2**N_REG_ADDR;
    localparam logic [N_CNT-1:0] CNT_MAX     = '1;
    localparam logic [N_CNT-1:0] CNT_TIMEOUT = N_CNT'(STALL_TIMEOUT);

    logic [N_REGS-1:0] r_pending;
    logic [N_CNT-1:0]  r_stall_cnt;
    logic              r_deadlock;

    logic              w_hit0;
    logic              w_hit1;
    logic              w_hitw;
    logic              w_hazard;
    logic [5:0]        w_stall;
    logic              w_issue;
    logic              w_set;
    logic              w_clr;
    logic [N_REGS-1:0] w_pending_nxt;

    // A register being written back this cycle is forwarded by the regfile, so it is not a hazard.
    function automatic logic hit(input logic [N_REG_ADDR-1:0] a,
                                 input logic [N_REGS-1:0]     pend,
                                 input logic                  wb_wen,
                                 input logic [N_REG_ADDR-1:0] wb_addr);
        return (a != '0) && pend[a] && !(wb_wen && (wb_addr == a));
    endfunction

    assign w_hit0   = i_id_reg_0_ren && hit(i_id_reg_0_addr, r_pending, i_wb_wen, i_wb_waddr);
    assign w_hit1   = i_id_reg_1_ren && hit(i_id_reg_1_addr, r_pending, i_wb_wen, i_wb_waddr);
    assign w_hitw   = i_id_reg_wen   && hit(i_id_reg_waddr,  r_pending, i_wb_wen, i_wb_waddr);
    assign w_hazard = i_id_valid && (w_hit0 || w_hit1 || w_hitw);

    always_comb begin
        w_stall = 6'b000000;
        w_issue = 1'b0;
        if (i_rst_n) begin
            if (i_flush) begin
                w_stall = 6'b000000;
            end else if (i_ex_stallreq) begin
                w_stall = 6'b001111;
            end else if (w_hazard) begin
                w_stall = 6'b000111;
            end
            w_issue = i_id_valid && !w_hazard && !i_ex_stallreq && !i_flush;
        end
    end

    assign w_set = w_issue && i_id_reg_wen && i_id_long && (i_id_reg_waddr != '0);
    assign w_clr = i_wb_wen && (i_wb_waddr != '0);

    // Clear before set so a younger writer to the same register keeps it pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_clr) begin
            w_pending_nxt[i_wb_waddr] = 1'b0;
        end
        if (w_set) begin
            w_pending_nxt[i_id_reg_waddr] = 1'b1;
        end
        if (i_flush) begin
            w_pending_nxt = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending   <= '0;
            r_stall_cnt <= '0;
            r_deadlock  <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_stall != 6'b000000) begin
                if (r_stall_cnt != CNT_MAX) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
                if (r_stall_cnt == CNT_TIMEOUT) begin
                    r_deadlock <= 1'b1;
                end
            end else begin
                r_stall_cnt <= '0;
            end
        end
    end

    assign o_stall     = w_stall;
    assign o_id_issue  = w_issue;
    assign o_pending   = r_pending;
    assign o_stall_cnt = r_stall_cnt;
    assign o_deadlock  = r_deadlock;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - directed and randomized bench for id_scoreboard against a behavioural model
module tb_id_scoreboard;

    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = 255;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        ren0;
    logic [4:0]  addr0;
    logic        ren1;
    logic [4:0]  addr1;
    logic        wen;
    logic [4:0]  waddr;
    logic        is_long;
    logic        ex_stallreq;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic        flush;
    logic [5:0]  o_stall;
    logic        o_id_issue;
    logic [31:0] o_pending;
    logic [7:0]  o_stall_cnt;
    logic        o_deadlock;

    int checks = 0;
    int errors = 0;

    bit m_pend [32];
    int m_cnt;
    bit m_dead;

    id_scoreboard #(
        .N_REG_ADDR    (5),
        .STALL_TIMEOUT (TIMEOUT),
        .N_CNT         (8)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_id_valid      (id_valid),
        .i_id_reg_0_ren  (ren0),
        .i_id_reg_0_addr (addr0),
        .i_id_reg_1_ren  (ren1),
        .i_id_reg_1_addr (addr1),
        .i_id_reg_wen    (wen),
        .i_id_reg_waddr  (waddr),
        .i_id_long       (is_long),
        .i_ex_stallreq   (ex_stallreq),
        .i_wb_wen        (wb_wen),
        .i_wb_waddr      (wb_waddr),
        .i_flush         (flush),
        .o_stall         (o_stall),
        .o_id_issue      (o_id_issue),
        .o_pending       (o_pending),
        .o_stall_cnt     (o_stall_cnt),
        .o_deadlock      (o_deadlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_hit(input int a);
        return (a != 0) && m_pend[a] && !(wb_wen && (int'(wb_waddr) == a));
    endfunction

    task automatic clr();
        rst_n = 1'b1; id_valid = 1'b0; ren0 = 1'b0; addr0 = '0; ren1 = 1'b0; addr1 = '0;
        wen = 1'b0; waddr = '0; is_long = 1'b0; ex_stallreq = 1'b0;
        wb_wen = 1'b0; wb_waddr = '0; flush = 1'b0;
    endtask

    // Called with inputs driven shortly after a falling edge; returns just after the next falling edge.
    task automatic step(input string tag);
        bit          hazard;
        logic [5:0]  exp_stall;
        logic        exp_issue;
        logic [31:0] exp_pend;
        #1;
        hazard = id_valid && ((ren0 && m_hit(int'(addr0))) || (ren1 && m_hit(int'(addr1)))
                              || (wen && m_hit(int'(waddr))));
        if (!rst_n || flush) exp_stall = 6'b000000;
        else if (ex_stallreq) exp_stall = 6'b001111;
        else if (hazard)      exp_stall = 6'b000111;
        else                  exp_stall = 6'b000000;
        exp_issue = rst_n && id_valid && !hazard && !ex_stallreq && !flush;

        checks++;
        assert (o_stall === exp_stall) else begin
            errors++;
            $error("FAIL %s stall observed=%b expected=%b", tag, o_stall, exp_stall);
        end
        checks++;
        assert (o_id_issue === exp_issue) else begin
            errors++;
            $error("FAIL %s issue observed=%b expected=%b", tag, o_id_issue, exp_issue);
        end

        if (!rst_n) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_cnt  = 0;
            m_dead = 1'b0;
        end else begin
            if (exp_stall != 0 && m_cnt == TIMEOUT) m_dead = 1'b1;
            m_cnt = (exp_stall != 0) ? ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1) : 0;
            if (wb_wen && wb_waddr != 0) m_pend[wb_waddr] = 1'b0;
            if (exp_issue && wen && is_long && waddr != 0) m_pend[waddr] = 1'b1;
            if (flush) foreach (m_pend[i]) m_pend[i] = 1'b0;
        end
        foreach (m_pend[i]) exp_pend[i] = m_pend[i];

        @(posedge clk);
        #1;
        checks++;
        assert (o_pending === exp_pend) else begin
            errors++;
            $error("FAIL %s pending observed=%h expected=%h", tag, o_pending, exp_pend);
        end
        checks++;
        assert (o_stall_cnt === 8'(m_cnt)) else begin
            errors++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, o_stall_cnt, m_cnt);
        end
        checks++;
        assert (o_deadlock === m_dead) else begin
            errors++;
            $error("FAIL %s deadlock observed=%b expected=%b", tag, o_deadlock, m_dead);
        end
        @(negedge clk);
    endtask

    initial begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt  = 0;
        m_dead = 1'b0;
        clr();
        rst_n = 1'b0;
        @(negedge clk);
        step("reset");
        step("reset2");

        // Long-latency issue, dependent read stalls until its writeback
        clr(); id_valid = 1; wen = 1; is_long = 1; waddr = 5; step("issue5");
        clr(); id_valid = 1; ren0 = 1; addr0 = 5;
        for (int i = 0; i < 3; i++) step("raw5");
        wb_wen = 1; wb_waddr = 5; step("wb5_bypass");
        clr(); id_valid = 1; ren1 = 1; addr1 = 5; step("after_wb5");

        // Register 0 is never tracked
        clr(); id_valid = 1; wen = 1; is_long = 1; waddr = 0; step("issue_r0");
        clr(); id_valid = 1; ren0 = 1; addr0 = 0; step("read_r0");

        // WAW with simultaneous writeback of the same register: set wins
        clr(); id_valid = 1; wen = 1; is_long = 1; waddr = 7; step("issue7");
        clr(); id_valid = 1; wen = 1; is_long = 1; waddr = 7; wb_wen = 1; wb_waddr = 7; step("waw7_setclr");
        clr(); id_valid = 1; wen = 1; waddr = 7; step("waw7_stall");

        // EX stall outranks ID hazard; flush outranks both and empties the bitmap
        clr(); id_valid = 1; ren0 = 1; addr0 = 7; ex_stallreq = 1; step("ex_prio");
        flush = 1; step("flush");
        clr(); id_valid = 1; ren0 = 1; addr0 = 7; step("post_flush");

        // Timeout: six EX stall cycles, flag stays set afterwards
        clr(); ex_stallreq = 1;
        for (int i = 0; i < 6; i++) step("timeout");
        clr(); step("timeout_drop");
        flush = 1; step("flush_keeps_deadlock");

        // Reset mid-stall with pending bits
        clr(); id_valid = 1; wen = 1; is_long = 1; waddr = 3; step("issue3");
        clr(); id_valid = 1; ren0 = 1; addr0 = 3; step("raw3");
        rst_n = 0; ex_stallreq = 1; step("reset_mid");
        clr(); id_valid = 1; ren0 = 1; addr0 = 3; step("after_reset");

        // Counter saturation
        clr(); ex_stallreq = 1;
        for (int i = 0; i < 260; i++) step("saturate");
        clr(); step("sat_drop");

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            ren0        = $urandom_range(0, 1);
            addr0       = 5'($urandom_range(0, 7));
            ren1        = $urandom_range(0, 1);
            addr1       = 5'($urandom_range(0, 7));
            wen         = $urandom_range(0, 1);
            waddr       = 5'($urandom_range(0, 7));
            is_long     = $urandom_range(0, 1);
            ex_stallreq = ($urandom_range(0, 5) == 0);
            wb_wen      = ($urandom_range(0, 2) == 0);
            wb_waddr    = 5'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 19) == 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
